pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 32 +++
 rtl/pipeline_ctrl_if.sv | 60 ++++++
 rtl/pipeline_ctrl_fwd_sel.sv | 33 +++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the five-stage pipeline hazard controller.
//   - forward-select encodings used by the EX-stage operand muxes
//   - resultSrc encoding that marks a load in EX
//   - state type of the multi-cycle (mul/div) occupancy FSM
//   - regHit helper: a write to rd is visible to a read of rs, never for x0
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   // Operand select for the EX-stage ALU inputs
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // resultSrc value carried by a load instruction
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // Width of the multi-cycle down-counter (covers MD_LAT up to 64)
   localparam int MD_CNT_W = 6;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } mdState_t;

   // x0 is hard-wired to zero, so it can never create a dependency
   function automatic logic regHit(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle of signals exchanged between the datapath and the hazard controller.
//   master : datapath side, drives register/stage info, receives controls
//   slave  : controller side, receives register/stage info, drives controls
// Datapath -> controller:
//   Rs1D, Rs2D       decode-stage source registers
//   Rs1E, Rs2E, RdE  ID/EX source and destination registers
//   resultSrcE       result source of EX instruction (01 = load)
//   pcSrcE           taken branch / jump resolved in EX
//   mdStartE         EX instruction is a multi-cycle op
//   RdM, regWriteM   MEM-stage writeback info
//   RdW, regWriteW   WB-stage writeback info
// Controller -> datapath:
//   stallF/D/E       hold PC, IF/ID, ID/EX
//   flushD/E/M       bubble IF/ID, ID/EX, EX/MEM
//   forwardAE/BE     ALU operand selects
//   mdBusy, mdDone   multi-cycle op status
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;

   logic [4:0] Rs1D;
   logic [4:0] Rs2D;
   logic [4:0] Rs1E;
   logic [4:0] Rs2E;
   logic [4:0] RdE;
   logic [1:0] resultSrcE;
   logic       pcSrcE;
   logic       mdStartE;
   logic [4:0] RdM;
   logic       regWriteM;
   logic [4:0] RdW;
   logic       regWriteW;

   logic       stallF;
   logic       stallD;
   logic       stallE;
   logic       flushD;
   logic       flushE;
   logic       flushM;
   logic [1:0] forwardAE;
   logic [1:0] forwardBE;
   logic       mdBusy;
   logic       mdDone;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, pcSrcE, mdStartE,
             RdM, regWriteM, RdW, regWriteW,
      input  stallF, stallD, stallE, flushD, flushE, flushM,
             forwardAE, forwardBE, mdBusy, mdDone
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, pcSrcE, mdStartE,
             RdM, regWriteM, RdW, regWriteW,
      output stallF, stallD, stallE, flushD, flushE, flushM,
             forwardAE, forwardBE, mdBusy, mdDone
   );

endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Forward-select for one EX-stage ALU operand. The youngest producer (MEM)
// wins over WB so the operand always sees the most recent write.
//   i_rs          source register of the operand in EX
//   i_rdM         destination register in MEM
//   i_regWriteM   MEM instruction writes the register file
//   i_rdW         destination register in WB
//   i_regWriteW   WB instruction writes the register file
//   o_fwd         FWD_MEM / FWD_WB / FWD_RF
// ---------------------------------------------------------------------------
module fwd_sel
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rdM,
   input  logic       i_regWriteM,
   input  logic [4:0] i_rdW,
   input  logic       i_regWriteW,
   output logic [1:0] o_fwd
);

   // Priority select: MEM result is newer than the WB result
   always_comb begin
      o_fwd = FWD_RF;
      if (i_regWriteM && regHit(i_rdM, i_rs)) begin
         o_fwd = FWD_MEM;
      end else if (i_regWriteW && regHit(i_rdW, i_rs)) begin
         o_fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard controller for a five-stage pipeline with a multi-cycle mul/div
// unit in EX. Produces stall/flush controls, operand forwarding selects and
// the multi-cycle occupancy status.
//   MD_LAT  EX cycles occupied by a mul/div op (2..64)
//   clk     rising-edge clock
//   rst     synchronous reset, active low
//   hz      pipeline_ctrl_if.slave bundle (stage info in, controls out)
// While rst is low every control output is forced to its idle value.
// ---------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MD_LAT = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_if.slave   hz
);

   // The RUN cycle that launches the op counts as the first of MD_LAT
   // cycles, and the counter reaching zero marks the last one.
   localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LAT - 2);

   mdState_t            r_state;
   logic [MD_CNT_W-1:0] r_mdCnt;

   mdState_t            w_nextState;
   logic [MD_CNT_W-1:0] w_nextMdCnt;
   logic                w_lwStall;
   logic [1:0]          w_fwdA;
   logic [1:0]          w_fwdB;

   logic                w_stallF;
   logic                w_stallD;
   logic                w_stallE;
   logic                w_flushD;
   logic                w_flushE;
   logic                w_flushM;
   logic                w_mdBusy;
   logic                w_mdDone;

   // Operand A reads Rs1E, operand B reads Rs2E
   fwd_sel u_fwdA (
      .i_rs        (hz.Rs1E),
      .i_rdM       (hz.RdM),
      .i_regWriteM (hz.regWriteM),
      .i_rdW       (hz.RdW),
      .i_regWriteW (hz.regWriteW),
      .o_fwd       (w_fwdA)
   );

   fwd_sel u_fwdB (
      .i_rs        (hz.Rs2E),
      .i_rdM       (hz.RdM),
      .i_regWriteM (hz.regWriteM),
      .i_rdW       (hz.RdW),
      .i_regWriteW (hz.regWriteW),
      .o_fwd       (w_fwdB)
   );

   // A load in EX whose destination the decode instruction reads must hold
   // decode one cycle and let a bubble into EX
   assign w_lwStall = (hz.resultSrcE == RESULT_SRC_LOAD) &&
                      (regHit(hz.RdE, hz.Rs1D) || regHit(hz.RdE, hz.Rs2D));

   // State register and occupancy counter; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_RUN;
         r_mdCnt <= '0;
      end else begin
         r_state <= w_nextState;
         r_mdCnt <= w_nextMdCnt;
      end
   end

   // Next-state and control outputs. In RUN the load-use and branch effects
   // are ORed together; a taken branch kills a multi-cycle op before it
   // starts. In MD_BUSY the EX instruction is frozen and only the counter
   // decides the controls. Reset overrides everything last.
   always_comb begin
      w_nextState = r_state;
      w_nextMdCnt = r_mdCnt;
      w_stallF    = 1'b0;
      w_stallD    = 1'b0;
      w_stallE    = 1'b0;
      w_flushD    = 1'b0;
      w_flushE    = 1'b0;
      w_flushM    = 1'b0;
      w_mdBusy    = 1'b0;
      w_mdDone    = 1'b0;

      case (r_state)
         ST_RUN: begin
            w_nextMdCnt = '0;
            if (w_lwStall) begin
               w_stallF = 1'b1;
               w_stallD = 1'b1;
               w_flushE = 1'b1;
            end
            if (hz.pcSrcE) begin
               w_flushD = 1'b1;
               w_flushE = 1'b1;
            end
            if (hz.mdStartE && !hz.pcSrcE) begin
               w_nextState = ST_MD_BUSY;
               w_nextMdCnt = MD_CNT_INIT;
               w_mdBusy    = 1'b1;
               w_stallF    = 1'b1;
               w_stallD    = 1'b1;
               w_stallE    = 1'b1;
               w_flushM    = 1'b1;
            end
         end

         ST_MD_BUSY: begin
            w_mdBusy = 1'b1;
            if (r_mdCnt != '0) begin
               w_nextMdCnt = r_mdCnt - 1'b1;
               w_stallF    = 1'b1;
               w_stallD    = 1'b1;
               w_stallE    = 1'b1;
               w_flushM    = 1'b1;
            end else begin
               w_nextState = ST_RUN;
               w_nextMdCnt = '0;
               w_mdDone    = 1'b1;
            end
         end

         default: begin
            w_nextState = ST_RUN;
            w_nextMdCnt = '0;
         end
      endcase

      if (!rst) begin
         w_stallF = 1'b0;
         w_stallD = 1'b0;
         w_stallE = 1'b0;
         w_flushD = 1'b0;
         w_flushE = 1'b0;
         w_flushM = 1'b0;
         w_mdBusy = 1'b0;
         w_mdDone = 1'b0;
      end
   end

   assign hz.stallF    = w_stallF;
   assign hz.stallD    = w_stallD;
   assign hz.stallE    = w_stallE;
   assign hz.flushD    = w_flushD;
   assign hz.flushE    = w_flushE;
   assign hz.flushM    = w_flushM;
   assign hz.mdBusy    = w_mdBusy;
   assign hz.mdDone    = w_mdDone;
   assign hz.forwardAE = rst ? w_fwdA : FWD_RF;
   assign hz.forwardBE = rst ? w_fwdB : FWD_RF;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl with MD_LAT = 4. Each step sets the
// inputs just after a rising edge, queues the expected control vector and
// compares it against the outputs at the following falling edge.
// Vector layout: {stallF,stallD,stallE,flushD,flushE,flushM,
//                 forwardAE[1:0],forwardBE[1:0],mdBusy,mdDone}
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int MD_LAT = 4;

   logic clk = 1'b0;
   logic rst;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [11:0] expected;
   } sbEntry_t;

   sbEntry_t scoreboard[$];

   pipeline_ctrl_if hz();

   pipeline_ctrl #(.MD_LAT(MD_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Guard against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Build an expected control vector
   function automatic logic [11:0] ev(
      input logic sF, input logic sD, input logic sE,
      input logic fD, input logic fE, input logic fM,
      input logic [1:0] fA, input logic [1:0] fB,
      input logic busy, input logic done);
      return {sF, sD, sE, fD, fE, fM, fA, fB, busy, done};
   endfunction

   // Quiet datapath: no hazards, no writes, no ops
   task automatic setIdle();
      hz.Rs1D       = 5'd0;
      hz.Rs2D       = 5'd0;
      hz.Rs1E       = 5'd0;
      hz.Rs2E       = 5'd0;
      hz.RdE        = 5'd0;
      hz.resultSrcE = 2'b00;
      hz.pcSrcE     = 1'b0;
      hz.mdStartE   = 1'b0;
      hz.RdM        = 5'd0;
      hz.regWriteM  = 1'b0;
      hz.RdW        = 5'd0;
      hz.regWriteW  = 1'b0;
   endtask

   // Queue the expected result for the inputs just driven
   task automatic applyStimulus(input string tag, input logic [11:0] expected);
      sbEntry_t e;
      e.tag      = tag;
      e.expected = expected;
      scoreboard.push_back(e);
   endtask

   // Sample on the falling edge and compare against the oldest queued entry
   task automatic checkOutput();
      sbEntry_t    e;
      logic [11:0] observed;
      @(negedge clk);
      observed = {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE,
                  hz.flushM, hz.forwardAE, hz.forwardBE, hz.mdBusy, hz.mdDone};
      checks++;
      if (scoreboard.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard_empty: observed=%b expected=entry", observed);
      end else begin
         e = scoreboard.pop_front();
         assert (observed === e.expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", e.tag, observed, e.expected);
         end
      end
   endtask

   // One full step: queue, check, then move to just after the next edge
   task automatic step(input string tag, input logic [11:0] expected);
      applyStimulus(tag, expected);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      logic [11:0] zero;
      logic [11:0] mdStall;
      logic [11:0] mdDoneVec;
      logic [11:0] lwVec;
      logic [11:0] brVec;

      zero      = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      mdStall   = ev(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0);
      mdDoneVec = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
      lwVec     = ev(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
      brVec     = ev(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0);

      // Reset held with every hazard input active
      setIdle();
      rst           = 1'b0;
      hz.pcSrcE     = 1'b1;
      hz.mdStartE   = 1'b1;
      hz.resultSrcE = 2'b01;
      hz.RdE        = 5'd7;
      hz.Rs2D       = 5'd7;
      hz.Rs1E       = 5'd5;
      hz.RdM        = 5'd5;
      hz.regWriteM  = 1'b1;
      step("reset_hold0", zero);
      step("reset_hold1", zero);

      rst = 1'b1;
      setIdle();
      step("idle_after_reset", zero);

      // Forwarding
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.regWriteM = 1'b1;
      hz.RdW = 5'd5; hz.regWriteW = 1'b1;
      step("fwdA_mem_priority", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
      hz.regWriteM = 1'b0;
      step("fwdA_wb", ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));

      setIdle();
      hz.Rs1E = 5'd3; hz.RdM = 5'd3; hz.regWriteM = 1'b1;
      hz.Rs2E = 5'd4; hz.RdW = 5'd4; hz.regWriteW = 1'b1;
      step("fwd_split", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0));

      setIdle();
      hz.Rs2E = 5'd6; hz.RdM = 5'd6; hz.regWriteM = 1'b1;
      step("fwdB_mem", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0));

      setIdle();
      hz.RdM = 5'd0; hz.regWriteM = 1'b1; hz.RdW = 5'd0; hz.regWriteW = 1'b1;
      step("fwd_x0", zero);

      setIdle();
      hz.Rs1E = 5'd8; hz.RdM = 5'd8; hz.regWriteM = 1'b0;
      step("fwd_no_write", zero);

      // Load-use
      setIdle();
      hz.resultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      step("lw_rs2", lwVec);
      setIdle();
      step("lw_cleared", zero);
      hz.resultSrcE = 2'b01; hz.RdE = 5'd12; hz.Rs1D = 5'd12;
      step("lw_rs1", lwVec);
      setIdle();
      hz.resultSrcE = 2'b01; hz.RdE = 5'd0; hz.Rs2D = 5'd0;
      step("lw_x0", zero);
      setIdle();
      hz.resultSrcE = 2'b00; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      step("lw_not_load", zero);

      // Control hazard, alone and combined with load-use
      setIdle();
      hz.pcSrcE = 1'b1;
      step("branch_flush", brVec);
      hz.resultSrcE = 2'b01; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
      step("lw_and_branch", ev(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));

      // Branch beats a multi-cycle start
      setIdle();
      hz.pcSrcE = 1'b1; hz.mdStartE = 1'b1;
      step("branch_beats_md", brVec);
      setIdle();
      step("still_run", zero);

      // Full multi-cycle op, hazards and forwarding while busy
      hz.mdStartE = 1'b1;
      step("md_c1", mdStall);
      setIdle();
      hz.pcSrcE = 1'b1; hz.resultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      step("md_c2_hazards_ignored", mdStall);
      setIdle();
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.regWriteM = 1'b1;
      step("md_c3_fwd", ev(1, 1, 1, 0, 0, 1, 2'b10, 2'b00, 1, 0));
      setIdle();
      step("md_c4_done", mdDoneVec);
      step("md_c5_run", zero);
      hz.pcSrcE = 1'b1;
      step("md_after_branch", brVec);

      // Reset in the second MD_BUSY cycle aborts the op
      setIdle();
      hz.mdStartE = 1'b1;
      step("abort_c1", mdStall);
      setIdle();
      step("abort_c2", mdStall);
      rst = 1'b0;
      step("abort_c3_reset", zero);
      rst = 1'b1;
      step("abort_release_no_done", zero);
      hz.pcSrcE = 1'b1;
      step("abort_run_branch", brVec);

      // A fresh op runs its full length after the abort
      setIdle();
      hz.mdStartE = 1'b1;
      step("restart_c1", mdStall);
      setIdle();
      step("restart_c2", mdStall);
      step("restart_c3", mdStall);
      step("restart_c4_done", mdDoneVec);
      step("restart_c5_run", zero);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
